motor_pwm_bank: RTL and testbench
=================================

Name: motor_pwm_bank

Overview:
- Multi-channel H-bridge PWM generator. It sits between the SOPC motor-controller register file and the 24-bit motor GPIO bus, which carries LEDs plus motor header pins.
- Turns per-channel duty/direction/brake words into glitch-free PWM, IN_A and IN_B outputs.
- Provides period-aligned updates, direction-change dead time, and a write-watchdog that coasts all motors if software stops refreshing.

Parameters:
- NUM_CH, 8, number of motor channels; gpio_out width is 3*NUM_CH.
- ADDR_W, 3, channel address width; must satisfy 2**ADDR_W >= NUM_CH.
- DUTY_W, 10, duty field width.
- PERIOD, 1000, PWM counts per period.
- PRESC, 5, clk_50 cycles per PWM count; default gives 10 kHz PWM at 50 MHz.
- DEAD_PERIODS, 2, full coast periods inserted on a direction reversal.
- WDOG_PERIODS, 100, periods without a write before trip; 0 disables the watchdog.

Ports:
- clk_50  in  1  system clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  one-cycle write strobe
- wr_addr  in  ADDR_W  channel index; writes with wr_addr >= NUM_CH are ignored and do not kick the watchdog
- wr_data  in  DUTY_W+2  [DUTY_W-1:0] duty, [DUTY_W] dir, [DUTY_W+1] brake
- global_enable  in  1  0 forces all channels to coast
- period_start  out  1  one-cycle pulse at each period boundary
- wdog_tripped  out  1  sticky watchdog flag
- gpio_out  out  3*NUM_CH  channel k occupies bits [3k+2:3k] = {in_b, in_a, pwm}

Behaviour:
- Reset: all of the following are cleared: every output, prescaler, period counter cnt, all pending/active registers, dead counters and the watchdog count. A reset asserted mid-period takes effect at the next edge; there is no partial-period completion.
- Prescaler: generates tick every PRESC clocks.
- Period counter: cnt advances on tick over 0..PERIOD-1.
- Boundary: tick && cnt==PERIOD-1. At a boundary, cnt returns to 0 and period_start pulses in the same cycle that cnt becomes 0.
- Writes: a valid write updates only the channel's pending register.
  - At the boundary, pending is copied to active, so there are no mid-period duty changes.
  - A write in the same cycle as a boundary lands in pending and is applied at the following boundary; the load uses the prior pending value.
- Duty clamp: duty values above PERIOD are clamped to PERIOD (100%).
- PWM output: pwm = (cnt < active_duty), registered, so it lags cnt by 1 clk.
  - duty 0 gives pwm constant 0.
  - duty PERIOD gives pwm constant 1.
- Per-channel FSM with states RUN and DEAD.
  - RUN, boundary load with new dir != active dir and brake=0: go to DEAD, dead_cnt=DEAD_PERIODS, active dir unchanged.
  - DEAD: outputs forced to {0,0,0}. dead_cnt decrements at each boundary. When it reaches 0, that same boundary loads the then-current pending value (dir and duty) and the FSM returns to RUN.
  - A write reversing direction back to the original during DEAD does not shorten DEAD.
  - DEAD_PERIODS=0 means a reversal applies immediately at the boundary.
- Output decode in RUN:
  - brake=1: {in_b,in_a,pwm} = {1,1,1}; brake ignores dir and takes effect at the boundary with no dead time.
  - brake=0: in_a = ~dir, in_b = dir, with in_a/in_b held even when pwm=0.
- Watchdog:
  - Counts boundaries since the last valid write; any valid write clears the count.
  - When the count reaches WDOG_PERIODS, wdog_tripped is set. At the same time all pending/active duty values are cleared to 0, brake is cleared, and the FSMs are forced to RUN.
  - While tripped, outputs are {0,0,0}.
  - wdog_tripped clears on the next valid write. That write's channel resumes at the next boundary; all other channels stay at duty 0.
- Simultaneous trip and write: the write wins. No trip occurs and the count clears.
- global_enable=0: the registered outputs are all 0 on the next clk. Counters, FSMs and the watchdog keep running. Re-enable restores the decode on the next clk, which may be mid-period.

Decomposition:
- Shared package motor_pwm_pkg holds:
  - wr_data field offsets (DUTY_LSB, DIR_BIT, BRAKE_BIT);
  - per-channel output bit offsets (PWM_OFS=0, INA_OFS=1, INB_OFS=2);
  - FSM state encoding (ST_RUN, ST_DEAD).
- Sub-module motor_pwm_channel holds the pending/active registers, clamp, dead-time FSM and output decode. It takes cnt, boundary, wdog_clear and enable, and is instantiated NUM_CH times via generate.
- The top holds the prescaler, period counter, watchdog and write decode.

Test Plan (bench parameters PERIOD=10, PRESC=1, DEAD_PERIODS=2, WDOG_PERIODS=5):
- Write ch0 duty=3 dir=0 mid-period -> unchanged until next period_start; then pwm high for 3 of 10 clks, in_a=1, in_b=0, steady each period.
- Write ch2 duty=15 -> clamped, pwm constant 1. Write duty=0 -> pwm constant 0 after the boundary. Write to wr_addr=7 with NUM_CH=6 -> no output change, and the watchdog still trips.
- ch1 running dir=0 duty=5, write dir=1 duty=5 -> 2 full periods of {0,0,0}, then in_b=1, in_a=0, pwm 5/10. A brake write -> {1,1,1} at the next boundary with no dead time.
- Write coincident with the boundary cycle -> the value is applied one period later (exactly 10 clks after that boundary).
- No writes for 5 periods -> wdog_tripped=1 and all gpio_out=0. Then write ch0 duty=4 -> flag clears immediately; ch0 resumes at the next boundary while the other channels stay 0.
- Assert reset mid-period with outputs active -> gpio_out, period_start and wdog_tripped are 0 the next clk. After release, the first period_start occurs 10 clks later.

Source files
------------

// File: rtl/motor_pwm_pkg.sv
// Shared field offsets and channel FSM encoding for the motor PWM bank.
package motor_pwm_pkg;

  // wr_data layout: duty field at DUTY_LSB; dir and brake sit just above the duty field
  localparam int unsigned DUTY_LSB  = 0;
  localparam int unsigned DIR_BIT   = 0;
  localparam int unsigned BRAKE_BIT = 1;

  localparam int unsigned PWM_OFS = 0;
  localparam int unsigned INA_OFS = 1;
  localparam int unsigned INB_OFS = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } ch_state_t;

endpackage

// File: rtl/motor_pwm_channel.sv
// One H-bridge channel: pending/active duty words, dead-time FSM on reversal,
// and registered {in_b, in_a, pwm} decode.
module motor_pwm_channel
  import motor_pwm_pkg::*;
#(
  parameter int unsigned DUTY_W       = 10,
  parameter int unsigned PERIOD       = 1000,
  parameter int unsigned DEAD_PERIODS = 2,
  parameter int unsigned CNT_W        = 10
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DUTY_W+1:0] wr_data,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              boundary,
  input  logic              wdog_clear,
  input  logic              enable,
  output logic [2:0]        pins
);

  localparam int unsigned DEAD_W = (DEAD_PERIODS > 0) ? $clog2(DEAD_PERIODS + 1) : 1;

  logic [DUTY_W-1:0] pend_duty;
  logic              pend_dir;
  logic              pend_brake;
  logic [CNT_W-1:0]  act_duty;
  logic              act_dir;
  logic              act_brake;
  logic [CNT_W-1:0]  load_duty;
  logic [DEAD_W-1:0] dead_cnt;
  ch_state_t         state;

  always_comb begin
    if (32'(pend_duty) > PERIOD) load_duty = CNT_W'(PERIOD);
    else                         load_duty = CNT_W'(pend_duty);
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      pend_duty  <= '0;
      pend_dir   <= 1'b0;
      pend_brake <= 1'b0;
      act_duty   <= '0;
      act_dir    <= 1'b0;
      act_brake  <= 1'b0;
      dead_cnt   <= '0;
      state      <= ST_RUN;
      pins       <= '0;
    end else begin
      // Decode uses pre-edge cnt/active, so pwm lags cnt by one clock
      if (!enable || state == ST_DEAD) begin
        pins <= '0;
      end else if (act_brake) begin
        pins <= '1;
      end else begin
        pins[PWM_OFS] <= (cnt < act_duty);
        pins[INA_OFS] <= ~act_dir;
        pins[INB_OFS] <= act_dir;
      end

      if (wdog_clear) begin
        pend_duty  <= '0;
        pend_brake <= 1'b0;
        act_duty   <= '0;
        act_brake  <= 1'b0;
        dead_cnt   <= '0;
        state      <= ST_RUN;
      end else begin
        if (boundary) begin
          case (state)
            ST_RUN: begin
              if (!pend_brake && pend_dir != act_dir && DEAD_PERIODS != 0) begin
                state    <= ST_DEAD;
                dead_cnt <= DEAD_W'(DEAD_PERIODS);
              end else begin
                act_duty  <= load_duty;
                act_dir   <= pend_dir;
                act_brake <= pend_brake;
              end
            end
            ST_DEAD: begin
              if (dead_cnt == DEAD_W'(1)) begin
                act_duty  <= load_duty;
                act_dir   <= pend_dir;
                act_brake <= pend_brake;
                dead_cnt  <= '0;
                state     <= ST_RUN;
              end else begin
                dead_cnt <= dead_cnt - DEAD_W'(1);
              end
            end
            default: state <= ST_RUN;
          endcase
        end
        // Non-blocking, so a load in this same cycle still sees the old pending word
        if (wr_en) begin
          pend_duty  <= wr_data[DUTY_LSB +: DUTY_W];
          pend_dir   <= wr_data[DUTY_W + DIR_BIT];
          pend_brake <= wr_data[DUTY_W + BRAKE_BIT];
        end
      end
    end
  end

endmodule

// File: rtl/motor_pwm_bank.sv
// Multi-channel H-bridge PWM bank: prescaler, period counter, write decode
// and write watchdog shared by NUM_CH channel instances.
module motor_pwm_bank
  import motor_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned DUTY_W       = 10,
  parameter int unsigned PERIOD       = 1000,
  parameter int unsigned PRESC        = 5,
  parameter int unsigned DEAD_PERIODS = 2,
  parameter int unsigned WDOG_PERIODS = 100
) (
  input  logic                clk_50,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DUTY_W+1:0]   wr_data,
  input  logic                global_enable,
  output logic                period_start,
  output logic                wdog_tripped,
  output logic [3*NUM_CH-1:0] gpio_out
);

  localparam int unsigned CNT_W   = $clog2(PERIOD + 1);
  localparam int unsigned PRE_W   = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int unsigned WD_W    = (WDOG_PERIODS > 0) ? $clog2(WDOG_PERIODS + 1) : 1;
  localparam int unsigned WD_LAST = (WDOG_PERIODS > 0) ? WDOG_PERIODS - 1 : 0;

  logic [PRE_W-1:0] presc_cnt;
  logic [CNT_W-1:0] cnt;
  logic [WD_W-1:0]  wdog_cnt;
  logic             tick;
  logic             boundary;
  logic             wr_valid;
  logic             trip;
  logic             ch_enable;

  always_comb begin
    tick      = (presc_cnt == PRE_W'(PRESC - 1));
    boundary  = tick && (cnt == CNT_W'(PERIOD - 1));
    wr_valid  = wr_en && (32'(wr_addr) < NUM_CH);
    // A valid write in the trip cycle suppresses the trip
    trip      = boundary && !wdog_tripped && (WDOG_PERIODS != 0) &&
                (wdog_cnt == WD_W'(WD_LAST)) && !wr_valid;
    ch_enable = global_enable && !wdog_tripped && !trip;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      presc_cnt    <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
      wdog_cnt     <= '0;
      wdog_tripped <= 1'b0;
    end else begin
      presc_cnt    <= tick ? '0 : presc_cnt + PRE_W'(1);
      period_start <= boundary;
      if (tick) cnt <= (cnt == CNT_W'(PERIOD - 1)) ? '0 : cnt + CNT_W'(1);

      if (wr_valid) begin
        wdog_cnt     <= '0;
        wdog_tripped <= 1'b0;
      end else if (trip) begin
        wdog_tripped <= 1'b1;
      end else if (boundary && !wdog_tripped && WDOG_PERIODS != 0) begin
        wdog_cnt <= wdog_cnt + WD_W'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    motor_pwm_channel #(
      .DUTY_W       (DUTY_W),
      .PERIOD       (PERIOD),
      .DEAD_PERIODS (DEAD_PERIODS),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk_50     (clk_50),
      .reset      (reset),
      .wr_en      (wr_valid && (wr_addr == ADDR_W'(k))),
      .wr_data    (wr_data),
      .cnt        (cnt),
      .boundary   (boundary),
      .wdog_clear (trip),
      .enable     (ch_enable),
      .pins       (gpio_out[3*k +: 3])
    );
  end

endmodule

// File: tb/tb_motor_pwm_bank.sv
// Scoreboard bench for motor_pwm_bank: a behavioural model predicts every
// cycle's outputs into a queue; a monitor pops and compares after each edge.
module tb_motor_pwm_bank;

  localparam int NUM_CH = 6;
  localparam int ADDR_W = 3;
  localparam int DUTY_W = 10;
  localparam int PERIOD = 10;
  localparam int PRESC  = 1;
  localparam int DEADP  = 2;
  localparam int WDOGP  = 5;
  localparam int GW     = 3 * NUM_CH;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DUTY_W+1:0] wr_data;
  logic              global_enable;
  logic              period_start;
  logic              wdog_tripped;
  logic [GW-1:0]     gpio_out;

  motor_pwm_bank #(
    .NUM_CH       (NUM_CH),
    .ADDR_W       (ADDR_W),
    .DUTY_W       (DUTY_W),
    .PERIOD       (PERIOD),
    .PRESC        (PRESC),
    .DEAD_PERIODS (DEADP),
    .WDOG_PERIODS (WDOGP)
  ) dut (
    .clk_50        (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .global_enable (global_enable),
    .period_start  (period_start),
    .wdog_tripped  (wdog_tripped),
    .gpio_out      (gpio_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ps;
    logic          wt;
    logic [GW-1:0] g;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state: plain integers, period phase derived from elapsed cycles
  int cyc;
  int wd;
  bit trp;
  int p_duty[NUM_CH], a_duty[NUM_CH], dead[NUM_CH];
  bit p_dir[NUM_CH], p_brk[NUM_CH], a_dir[NUM_CH], a_brk[NUM_CH];
  int m_phase;
  bit m_bnd, m_vw, m_trip, m_en;
  exp_t m_e;

  function automatic int phase_now(input int c);
    return (c / PRESC) % PERIOD;
  endfunction

  task automatic load_ch(input int ch);
    a_duty[ch] = (p_duty[ch] > PERIOD) ? PERIOD : p_duty[ch];
    a_dir[ch]  = p_dir[ch];
    a_brk[ch]  = p_brk[ch];
  endtask

  always @(posedge clk) begin : model
    if (reset) begin
      cyc = 0; wd = 0; trp = 0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        p_duty[ch] = 0; p_dir[ch] = 0; p_brk[ch] = 0;
        a_duty[ch] = 0; a_dir[ch] = 0; a_brk[ch] = 0; dead[ch] = 0;
      end
      m_e.ps = 0; m_e.wt = 0; m_e.g = '0;
    end else begin
      m_phase = phase_now(cyc);
      m_bnd   = (cyc % PRESC == PRESC - 1) && (m_phase == PERIOD - 1);
      m_vw    = wr_en && (int'(wr_addr) < NUM_CH);
      m_trip  = m_bnd && !trp && (WDOGP > 0) && !m_vw && (wd + 1 == WDOGP);
      m_en    = global_enable && !trp && !m_trip;
      m_e.ps  = m_bnd;
      m_e.wt  = m_vw ? 1'b0 : (m_trip || trp);
      m_e.g   = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (m_en && dead[ch] == 0) begin
          if (a_brk[ch]) m_e.g[3*ch +: 3] = 3'b111;
          else m_e.g[3*ch +: 3] = {a_dir[ch], !a_dir[ch], (m_phase < a_duty[ch])};
        end
      end
      if (m_trip) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          p_duty[ch] = 0; p_brk[ch] = 0; a_duty[ch] = 0; a_brk[ch] = 0; dead[ch] = 0;
        end
      end else if (m_bnd) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (dead[ch] > 0) begin
            dead[ch]--;
            if (dead[ch] == 0) load_ch(ch);
          end else if (!p_brk[ch] && p_dir[ch] != a_dir[ch] && DEADP > 0) begin
            dead[ch] = DEADP;
          end else begin
            load_ch(ch);
          end
        end
      end
      if (m_vw) begin
        p_duty[wr_addr] = int'(wr_data[DUTY_W-1:0]);
        p_dir[wr_addr]  = wr_data[DUTY_W];
        p_brk[wr_addr]  = wr_data[DUTY_W+1];
        wd = 0; trp = 0;
      end else if (m_trip) begin
        trp = 1;
      end else if (m_bnd && !trp && WDOGP > 0) begin
        wd++;
      end
      cyc++;
    end
    q.push_back(m_e);
  end

  exp_t mon_e;
  always @(posedge clk) begin : monitor
    #1;
    n_cmp++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      mon_e = q.pop_front();
      if ({period_start, wdog_tripped, gpio_out} !== {mon_e.ps, mon_e.wt, mon_e.g}) begin
        n_err++;
        $display("FAIL cycle_outputs t=%0t got ps=%b wt=%b gpio=%h, expected ps=%b wt=%b gpio=%h",
                 $time, period_start, wdog_tripped, gpio_out, mon_e.ps, mon_e.wt, mon_e.g);
      end
    end
  end

  task automatic wr(input int a, input bit d, input bit b, input int duty);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = {b, d, DUTY_W'(duty)};
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic to_phase(input int p);
    int k = 0;
    while (phase_now(cyc) != p && k < 4 * PERIOD * PRESC) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_first_ps();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start && k < 4 * PERIOD * PRESC);
    n_cmp++;
    if (k != PERIOD * PRESC) begin
      n_err++;
      $display("FAIL first_period_start got %0d clks, expected %0d", k, PERIOD * PRESC);
    end
  endtask

  task automatic check_val(input string name, input logic [GW+1:0] got, input logic [GW+1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %h, expected %h", name, got, want);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; global_enable = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_first_ps();

    // basic duty/direction, clamp, duty 0, out-of-range address
    to_phase(4); wr(0, 0, 0, 3); idle(30);
    wr(2, 0, 0, 15); idle(25);
    wr(2, 0, 0, 0);  idle(25);
    wr(7, 1, 1, 9);  idle(15);

    // reversal with dead time, then brake
    wr(1, 0, 0, 5); idle(25);
    to_phase(3); wr(1, 1, 0, 5); idle(45);
    wr(1, 0, 1, 2); idle(25);

    // reversal then reverting during dead time
    wr(4, 1, 0, 6); idle(15);
    to_phase(2); wr(4, 0, 0, 6); to_phase(6); wr(4, 1, 0, 6); idle(40);

    // write coincident with boundary
    to_phase(PERIOD - 1); wr(3, 0, 0, 6); idle(25);

    // global enable drop mid-period
    to_phase(4); global_enable = 1'b0; idle(7); global_enable = 1'b1; idle(15);

    // watchdog trip, only out-of-range writes in between
    wr(0, 0, 0, 7); idle(20); wr(7, 0, 0, 1); idle(30); wr(7, 0, 0, 2); idle(20);
    check_val("wdog_tripped_state", {wdog_tripped, period_start, gpio_out}, {1'b1, 1'b0, {GW{1'b0}}});
    wr(0, 0, 0, 4);
    check_val("wdog_clear_on_write", {1'b0, wdog_tripped, {GW{1'b0}}}, '0);
    idle(25);

    // randomized traffic with a silent stretch
    for (int i = 0; i < 400; i++) begin
      if (!(i >= 150 && i < 220) && $urandom_range(0, 7) == 0) begin
        wr_en   = 1'b1;
        wr_addr = ADDR_W'($urandom_range(0, 7));
        wr_data = {($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), DUTY_W'($urandom_range(0, 15))};
      end else begin
        wr_en = 1'b0;
      end
      if ($urandom_range(0, 31) == 0) global_enable = ~global_enable;
      @(negedge clk);
    end
    wr_en = 1'b0; global_enable = 1'b1;

    // reset mid-period with outputs active
    wr(0, 0, 0, 6); wr(5, 0, 1, 3); idle(25);
    to_phase(5); reset = 1'b1;
    @(negedge clk);
    check_val("reset_clears_outputs", {wdog_tripped, period_start, gpio_out}, '0);
    reset = 1'b0;
    check_first_ps();
    idle(25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
